// File: rtl/lift_call_scheduler.sv
// -----------------------------------------------------------------------------
// lift_call_scheduler
//
// Purpose:
//   Latches hall calls (up/down per floor) and in-car calls, picks the next
//   target floor with a collective-directional SCAN policy and offers it to
//   the car datapath over a valid/ready handshake. Served calls are cleared
//   when the car reports arrival, and the current travel direction is output.
//
// Optional feature:
//   LIFT_SCHED_TIMEOUT_EN - when defined, a 16-bit watchdog counts cycles spent
//   waiting for arrival. Reaching TIMEOUT_CYCLES raises the sticky o_fault,
//   returns the FSM to IDLE (pending calls kept) and blocks further dispatch
//   until reset. When undefined, o_fault is tied low and TRAVEL waits forever.
//
// Parameters:
//   NUM_FLOORS      floors served (2..32), floor index is 5 bits
//   TIMEOUT_CYCLES  arrival watchdog limit (only with LIFT_SCHED_TIMEOUT_EN)
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_hall_up     up hall-call pulses per floor (top floor bit ignored)
//   i_hall_dn     down hall-call pulses per floor (floor 0 bit ignored)
//   i_car_call    in-car floor button pulses
//   i_curr_floor  current car floor (values >= NUM_FLOORS clamp to the top)
//   i_req_ready   datapath accepts the offered target
//   i_arrived     pulse: car stopped at accepted target, doors open
//   o_target      offered target floor, stable while o_req_valid is high
//   o_req_valid   target offered
//   o_dir         00 idle, 01 up, 10 down
//   o_pend_up/o_pend_dn/o_pend_car  pending-call registers
//   o_fault       sticky watchdog fault
// -----------------------------------------------------------------------------
module lift_call_scheduler #(
  parameter int NUM_FLOORS     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_FLOORS-1:0] i_hall_up,
  input  logic [NUM_FLOORS-1:0] i_hall_dn,
  input  logic [NUM_FLOORS-1:0] i_car_call,
  input  logic [4:0]            i_curr_floor,
  input  logic                  i_req_ready,
  input  logic                  i_arrived,
  output logic [4:0]            o_target,
  output logic                  o_req_valid,
  output logic [1:0]            o_dir,
  output logic [NUM_FLOORS-1:0] o_pend_up,
  output logic [NUM_FLOORS-1:0] o_pend_dn,
  output logic [NUM_FLOORS-1:0] o_pend_car,
  output logic                  o_fault
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_TRAVEL   = 2'd3
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam logic [NUM_FLOORS-1:0] ZERO_V = {NUM_FLOORS{1'b0}};
  // No up call exists at the top floor and no down call at floor 0.
  localparam logic [NUM_FLOORS-1:0] UP_OK_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_OK_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  // Elaboration-time parameter sanity checks.
  if (NUM_FLOORS < 2 || NUM_FLOORS > 32) begin : g_bad_floors
    $error("lift_call_scheduler: NUM_FLOORS must be 2..32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("lift_call_scheduler: TIMEOUT_CYCLES must be 1..65536");
  end

  // ---------------------------------------------------------------------------
  // Floor-vector helpers
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [4:0] c);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (5'(i) > c);
    end
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [4:0] c);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (5'(i) < c);
    end
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] one_hot(input logic [4:0] c);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (5'(i) == c);
    end
    return m;
  endfunction

  function automatic logic [4:0] lowest_idx(input logic [NUM_FLOORS-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [4:0] highest_idx(input logic [NUM_FLOORS-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_r, state_nxt_s;
  logic [4:0]            target_r, target_nxt_s;
  logic                  valid_r, valid_nxt_s;
  logic [1:0]            dir_r, dir_nxt_s;
  logic [NUM_FLOORS-1:0] pend_car_r, pend_up_r, pend_dn_r;

  logic [4:0]            cf_s;
  logic [NUM_FLOORS-1:0] all_pend_s;
  logic                  any_pend_s;
  logic [NUM_FLOORS-1:0] above_s, below_s;
  logic [NUM_FLOORS-1:0] up_near_s, up_far_s, dn_near_s, dn_far_s;
  logic                  here_s;
  logic                  up_found_s, dn_found_s, sel_found_s;
  logic [4:0]            up_floor_s, dn_floor_s, sel_floor_s;
  logic [1:0]            sel_dir_s;

  logic                  arrive_s;
  logic [NUM_FLOORS-1:0] tgt_hot_s;
  logic                  beyond_up_s, beyond_dn_s;
  logic [NUM_FLOORS-1:0] clr_car_s, clr_up_s, clr_dn_s;

  logic                  tmo_hit_s;
  logic                  hold_s;

  // Out-of-range floor reports clamp to the top floor.
  assign cf_s = ({1'b0, i_curr_floor} >= 6'(NUM_FLOORS)) ? 5'(NUM_FLOORS - 1)
                                                         : i_curr_floor;

  assign all_pend_s = pend_car_r | pend_up_r | pend_dn_r;
  assign any_pend_s = |all_pend_s;

  // ---------------------------------------------------------------------------
  // SCAN target selection (evaluated on registered pending state)
  // ---------------------------------------------------------------------------
  assign above_s   = above_mask(cf_s);
  assign below_s   = below_mask(cf_s);
  // Going up: stop for car/up calls above first, then the farthest down call.
  assign up_near_s = (pend_car_r | pend_up_r) & above_s;
  assign up_far_s  = pend_dn_r & above_s;
  // Going down: mirror image.
  assign dn_near_s = (pend_car_r | pend_dn_r) & below_s;
  assign dn_far_s  = pend_up_r & below_s;
  assign here_s    = |(all_pend_s & one_hot(cf_s));

  // Directional searches and final choice of target floor and direction.
  always_comb begin
    up_found_s  = 1'b1;
    up_floor_s  = 5'd0;
    dn_found_s  = 1'b1;
    dn_floor_s  = 5'd0;
    sel_found_s = 1'b1;
    sel_floor_s = cf_s;
    sel_dir_s   = dir_r;

    if (|up_near_s) begin
      up_floor_s = lowest_idx(up_near_s);
    end else if (|up_far_s) begin
      up_floor_s = highest_idx(up_far_s);
    end else begin
      up_found_s = 1'b0;
    end

    if (|dn_near_s) begin
      dn_floor_s = highest_idx(dn_near_s);
    end else if (|dn_far_s) begin
      dn_floor_s = lowest_idx(dn_far_s);
    end else begin
      dn_found_s = 1'b0;
    end

    if (dir_r == DIR_DN) begin
      if (dn_found_s) begin
        sel_floor_s = dn_floor_s;
      end else if (up_found_s) begin
        sel_floor_s = up_floor_s;
      end else if (here_s) begin
        sel_floor_s = cf_s;
      end else begin
        sel_found_s = 1'b0;
      end
    end else begin
      if (up_found_s) begin
        sel_floor_s = up_floor_s;
      end else if (dn_found_s) begin
        sel_floor_s = dn_floor_s;
      end else if (here_s) begin
        sel_floor_s = cf_s;
      end else begin
        sel_found_s = 1'b0;
      end
    end

    // A stop at the current floor keeps the heading; from idle it counts as up.
    if (sel_floor_s > cf_s) begin
      sel_dir_s = DIR_UP;
    end else if (sel_floor_s < cf_s) begin
      sel_dir_s = DIR_DN;
    end else if (dir_r == DIR_IDLE) begin
      sel_dir_s = DIR_UP;
    end else begin
      sel_dir_s = dir_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Service clearing on arrival
  // ---------------------------------------------------------------------------
  assign arrive_s    = (state_r == ST_TRAVEL) && i_arrived;
  assign tgt_hot_s   = one_hot(target_r);
  assign beyond_up_s = |(all_pend_s & above_mask(target_r));
  assign beyond_dn_s = |(all_pend_s & below_mask(target_r));

  // Decide which pending bits at the target floor the arrival serves. The
  // opposite hall call is also served when the car will reverse there.
  always_comb begin
    clr_car_s = ZERO_V;
    clr_up_s  = ZERO_V;
    clr_dn_s  = ZERO_V;
    if (arrive_s) begin
      clr_car_s = tgt_hot_s;
      if (dir_r == DIR_UP) begin
        clr_up_s = tgt_hot_s;
        clr_dn_s = beyond_up_s ? ZERO_V : tgt_hot_s;
      end else if (dir_r == DIR_DN) begin
        clr_dn_s = tgt_hot_s;
        clr_up_s = beyond_dn_s ? ZERO_V : tgt_hot_s;
      end else begin
        clr_up_s = ZERO_V;
        clr_dn_s = ZERO_V;
      end
    end else begin
      clr_car_s = ZERO_V;
    end
  end

  // Pending-call registers: a new pulse wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_car_r <= ZERO_V;
      pend_up_r  <= ZERO_V;
      pend_dn_r  <= ZERO_V;
    end else begin
      pend_car_r <= (pend_car_r & ~clr_car_s) | i_car_call;
      pend_up_r  <= (pend_up_r  & ~clr_up_s)  | (i_hall_up & UP_OK_MASK);
      pend_dn_r  <= (pend_dn_r  & ~clr_dn_s)  | (i_hall_dn & DN_OK_MASK);
    end
  end

  // ---------------------------------------------------------------------------
  // Arrival watchdog
  // ---------------------------------------------------------------------------
`ifdef LIFT_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;
  logic        fault_r;

  assign tmo_hit_s = (state_r == ST_TRAVEL) && !i_arrived &&
                     (tmo_cnt_r >= 16'(TIMEOUT_CYCLES - 1));
  assign hold_s    = fault_r;
  assign o_fault   = fault_r;

  // Watchdog counter restarts on every TRAVEL entry; fault is sticky.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_r <= 16'd0;
      fault_r   <= 1'b0;
    end else begin
      if (state_r == ST_TRAVEL) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end else begin
        tmo_cnt_r <= 16'd0;
      end
      if (tmo_hit_s) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign hold_s    = 1'b0;
  assign o_fault   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    valid_nxt_s  = valid_r;
    dir_nxt_s    = dir_r;
    case (state_r)
      ST_IDLE: begin
        valid_nxt_s = 1'b0;
        if (any_pend_s && !hold_s) begin
          state_nxt_s = ST_SELECT;
        end else if (!any_pend_s) begin
          dir_nxt_s = DIR_IDLE;
        end else begin
          dir_nxt_s = dir_r;
        end
      end
      ST_SELECT: begin
        if (sel_found_s) begin
          target_nxt_s = sel_floor_s;
          dir_nxt_s    = sel_dir_s;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = ST_DISPATCH;
        end else begin
          valid_nxt_s  = 1'b0;
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (i_req_ready) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_TRAVEL;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      ST_TRAVEL: begin
        valid_nxt_s = 1'b0;
        if (arrive_s) begin
          state_nxt_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TRAVEL;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      target_r <= 5'd0;
      valid_r  <= 1'b0;
      dir_r    <= DIR_IDLE;
    end else begin
      state_r  <= state_nxt_s;
      target_r <= target_nxt_s;
      valid_r  <= valid_nxt_s;
      dir_r    <= dir_nxt_s;
    end
  end

  assign o_target    = target_r;
  assign o_req_valid = valid_r;
  assign o_dir       = dir_r;
  assign o_pend_up   = pend_up_r;
  assign o_pend_dn   = pend_dn_r;
  assign o_pend_car  = pend_car_r;

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Request scheduler for the lift car controller. It latches hall calls (up/down per floor) and car calls, selects the next target floor with a SCAN (collective-directional) policy, and hands the target to the car datapath over a valid/ready handshake. It clears served calls on arrival and reports the travel direction. It sits between the call-button inputs and the lift motion/door controller.

## Interface
- NUM_FLOORS, 32: floors served, 2..32; floor index is 5 bits.
- TIMEOUT_CYCLES, 1024: arrival watchdog limit; used only when LIFT_SCHED_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock; all logic updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hall_up  in  NUM_FLOORS  one-cycle pulses, up-call per floor; top-floor bit ignored.
- i_hall_dn  in  NUM_FLOORS  one-cycle pulses, down-call per floor; floor-0 bit ignored.
- i_car_call  in  NUM_FLOORS  one-cycle pulses, in-car floor buttons.
- i_curr_floor  in  5  current car floor from the datapath.
- i_req_ready  in  1  datapath accepts a target.
- i_arrived  in  1  one-cycle pulse: car is stopped at the accepted target with doors open.
- o_target  out  5  target floor; stable while o_req_valid is high.
- o_req_valid  out  1  target offered.
- o_dir  out  2  00 idle, 01 up, 10 down.
- o_pend_up, o_pend_dn, o_pend_car  out  NUM_FLOORS each  pending-call registers.
- o_fault  out  1  sticky watchdog fault.

## Operation
- Pending registers set on pulse, cleared on service. A set pulse and a clear for the same bit in the same cycle leave the bit set.
- FSM states: IDLE, SELECT, DISPATCH, TRAVEL.
- IDLE: if any pending bit is set, go to SELECT. Otherwise o_dir=00.
- SELECT (1 cycle): compute the target from registered pending state and i_curr_floor (= c).
  - Dir up, or idle: lowest f>c with car|up. Else highest f>c with dn. Else the down search below. Else f=c if any call at c. Else return to IDLE.
  - Dir down: mirror image. Highest f<c with car|dn. Else lowest f<c with up. Else the up search. Else f=c.
  - o_dir is set from the sign of (f−c). It holds its previous value when f==c; from idle with f==c it is 01.
  - Go to DISPATCH.
- DISPATCH: o_req_valid=1, o_target=f. On i_req_ready go to TRAVEL.
- TRAVEL: wait for i_arrived. On i_arrived:
  - Clear car[f].
  - Clear up[f] if o_dir=01, or dn[f] if o_dir=10.
  - If no further call exists in o_dir beyond f, also clear the opposite hall bit at f.
  - Go to IDLE.
- Retargeting: there is none. A new nearer call waits for the next SELECT.

## Timing
- Reset values:
  - FSM in IDLE.
  - All pending registers 0.
  - o_target=0, o_req_valid=0, o_dir=00, o_fault=0.
- Latency from idle: a call pulse at edge N is in pending at N. SELECT is at N+1. o_req_valid is high from N+2.
- Handshake: the transfer happens on an edge with o_req_valid&&i_req_ready. o_req_valid drops on the following cycle. o_target must not change while valid is high.
- i_arrived outside TRAVEL is ignored.
- Asynchronous reset mid-operation aborts immediately: valid drops and all calls are lost.
- i_curr_floor ≥ NUM_FLOORS is treated as NUM_FLOORS−1.

## Configuration
- LIFT_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter runs in TRAVEL and resets on state entry.
  - Reaching TIMEOUT_CYCLES without i_arrived sets o_fault and returns the FSM to IDLE. Pending bits are preserved.
  - o_fault clears only on reset. While o_fault=1, IDLE does not leave.
- Not defined: no counter, o_fault tied 0, TRAVEL waits indefinitely.

## Test plan
- Car at 0, car_call[5] pulse, ready=1 -> valid at N+2 with target=5, dir=01; after i_arrived, pend_car[5]=0, FSM IDLE, valid=0.
- Car at 3 going up, pending car[7], hall_dn[9], hall_up[1] -> targets served in order 7, 9, then 1 (dir 10 after 9).
- hall_dn[0] and hall_up[NUM_FLOORS−1] pulses -> pending stays 0, no request issued.
- ready held 0 for 10 cycles -> valid stays high, target constant; ready=1 -> valid low next cycle.
- New car_call[5] pulse in the same cycle as i_arrived at 5 -> pend_car[5] remains 1.
- With LIFT_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no i_arrived -> o_fault=1 after 16 TRAVEL cycles; pending preserved; reset clears o_fault.
